// File: rtl/dpram_pkg.sv
// Shared defaults and FSM state type for the dual-port RAM responder.
package dpram_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/dpram_if.sv
// Request/response bundle between the bench driver (master) and the responder (slave).
interface dpram_if
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] w_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              busy;
  logic              collision;
  logic              req_dropped;

  modport master (
    output wr_en, wr_addr, w_data, rd_en, rd_addr,
    input  r_data, r_valid, busy, collision, req_dropped
  );

  modport slave (
    input  wr_en, wr_addr, w_data, rd_en, rd_addr,
    output r_data, r_valid, busy, collision, req_dropped
  );

endinterface

// File: rtl/dpram_core.sv
// 1W1R storage array: synchronous write, registered read, write-first on same-address access.
module dpram_core #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/dpram_responder.sv
// DUT-side responder: post-reset memory clear, 1-cycle reads, collision and dropped-request flags.
module dpram_responder
  import dpram_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic   clk,
  input  logic   rst,
  dpram_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic r_valid_q, busy_q, collision_q, dropped_q;
  logic r_valid_d, busy_d, collision_d, dropped_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (ptr_q == LAST_PTR) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Output logic: core port mux and next values of the registered flags
  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    r_valid_d   = 1'b0;
    busy_d      = 1'b0;
    collision_d = 1'b0;
    dropped_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_VAL;
        busy_d    = (ptr_q != LAST_PTR);
        dropped_d = bus.wr_en | bus.rd_en;
      end
      READY: begin
        mem_we      = bus.wr_en;
        mem_waddr   = bus.wr_addr;
        mem_wdata   = bus.w_data;
        mem_re      = bus.rd_en;
        r_valid_d   = bus.rd_en;
        collision_d = bus.wr_en & bus.rd_en & (bus.wr_addr == bus.rd_addr);
      end
      default: ;
    endcase
    // A request coinciding with the reset edge must not touch memory.
    if (!rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // Clear pointer and registered flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= '0;
      r_valid_q   <= 1'b0;
      busy_q      <= 1'b1;
      collision_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      if (state_q == CLEAR) begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
      r_valid_q   <= r_valid_d;
      busy_q      <= busy_d;
      collision_q <= collision_d;
      dropped_q   <= dropped_d;
    end
  end

  dpram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (bus.rd_addr),
    .rdata (mem_rdata)
  );

  assign bus.r_data      = mem_rdata;
  assign bus.r_valid     = r_valid_q;
  assign bus.busy        = busy_q;
  assign bus.collision   = collision_q;
  assign bus.req_dropped = dropped_q;

endmodule

// File: tb/tb_dpram_responder.sv
// Scenario bench for dpram_responder with a read-data scoreboard backed by a memory model.
module tb_dpram_responder;

  logic clk = 1'b0;
  logic rst;

  dpram_if bus ();

  dpram_responder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [32];
  logic [7:0] sb [$];
  logic [7:0] exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests; when live, record expected read data and update the model.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                       input logic re, input logic [4:0] ra, input bit live);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.w_data  = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    if (live) begin
      if (re) sb.push_back((we && (wa == ra)) ? wd : model[ra]);
      if (we) model[wa] = wd;
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r_valid: got %b want 0", bus.r_valid); end
    n_tests++; if (bus.r_data !== 8'h00) begin n_fail++; $display("FAIL rst_r_data: got %h want 00", bus.r_data); end
    n_tests++; if (bus.collision !== 1'b0) begin n_fail++; $display("FAIL rst_collision: got %b want 0", bus.collision); end
    n_tests++; if (bus.req_dropped !== 1'b0) begin n_fail++; $display("FAIL rst_dropped: got %b want 0", bus.req_dropped); end
    model_clear();
    rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_tests++;
      if (bus.busy !== logic'(k < 32)) begin
        n_fail++; $display("FAIL clear_busy edge %0d: got %b want %b", k, bus.busy, k < 32);
      end
    end
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 8'd0, 1'b1, 5'(a), 1'b1);
      tick();
      n_tests++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL clear_rd_valid addr %0d: got %b want 1", a, bus.r_valid); end
      exp_d = sb.pop_front();
      n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL clear_rd_data addr %0d: got %h want %h", a, bus.r_data, exp_d); end
    end
    idle();
    tick();
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL clear_idle_valid: got %b want 0", bus.r_valid); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 1'b1);
    tick();
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL wr_only_valid: got %b want 0", bus.r_valid); end
    drive(1'b0, 5'd0, 8'd0, 1'b1, 5'd3, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b want 1", bus.r_valid); end
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL wr_rd_data: got %h want %h", bus.r_data, exp_d); end
    n_tests++; if (bus.collision !== 1'b0) begin n_fail++; $display("FAIL wr_rd_collision: got %b want 0", bus.collision); end
    idle();
    tick();
    n_tests++; if (bus.r_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_hold: got %h want a5", bus.r_data); end
  endtask

  task automatic test_collision();
    drive(1'b1, 5'd7, 8'h3C, 1'b1, 5'd7, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b want 1", bus.collision); end
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL coll_bypass: got %h want %h", bus.r_data, exp_d); end
    drive(1'b1, 5'd8, 8'h11, 1'b1, 5'd7, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.collision !== 1'b0) begin n_fail++; $display("FAIL coll_pulse: got %b want 0", bus.collision); end
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL coll_mem: got %h want %h", bus.r_data, exp_d); end
    drive(1'b0, 5'd0, 8'd0, 1'b1, 5'd8, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL diff_addr_write: got %h want %h", bus.r_data, exp_d); end
    idle();
    tick();
  endtask

  task automatic test_dropped();
    int e;
    rst = 1'b0;
    idle();
    tick();
    model_clear();
    rst = 1'b1;
    tick();
    e = 1;
    drive(1'b1, 5'd0, 8'hFF, 1'b0, 5'd0, 1'b0);
    tick();
    e++;
    n_tests++; if (bus.req_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_wr: got %b want 1", bus.req_dropped); end
    drive(1'b0, 5'd0, 8'd0, 1'b1, 5'd0, 1'b0);
    tick();
    e++;
    n_tests++; if (bus.req_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_rd: got %b want 1", bus.req_dropped); end
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL drop_rd_valid: got %b want 0", bus.r_valid); end
    idle();
    tick();
    e++;
    n_tests++; if (bus.req_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %b want 0", bus.req_dropped); end
    while (bus.busy === 1'b1 && e < 40) begin
      tick();
      e++;
    end
    n_tests++; if (e !== 32) begin n_fail++; $display("FAIL drop_clear_len: got %0d edges want 32", e); end
    drive(1'b0, 5'd0, 8'd0, 1'b1, 5'd0, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL drop_addr0: got %h want %h", bus.r_data, exp_d); end
    idle();
    tick();
  endtask

  task automatic test_mid_reset();
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 8'(a), 1'b0, 5'd0, 1'b1);
      tick();
    end
    drive(1'b0, 5'd0, 8'd0, 1'b1, 5'd31, 1'b1);
    tick();
    exp_d = sb.pop_front();
    n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL fill_rd31: got %h want %h", bus.r_data, exp_d); end
    rst = 1'b0;
    drive(1'b1, 5'd4, 8'hEE, 1'b1, 5'd4, 1'b0);
    tick();
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.r_valid); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b want 1", bus.busy); end
    n_tests++; if (bus.collision !== 1'b0) begin n_fail++; $display("FAIL midrst_coll: got %b want 0", bus.collision); end
    model_clear();
    rst = 1'b1;
    idle();
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_tests++;
      if (bus.busy !== logic'(k < 32)) begin
        n_fail++; $display("FAIL midrst_busy edge %0d: got %b want %b", k, bus.busy, k < 32);
      end
    end
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 8'd0, 1'b1, 5'(a), 1'b1);
      tick();
      exp_d = sb.pop_front();
      n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL midrst_rd addr %0d: got %h want %h", a, bus.r_data, exp_d); end
    end
    idle();
    tick();
  endtask

  task automatic test_streaming();
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 8'(a) ^ 8'h5A, 1'b0, 5'd0, 1'b1);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 8'd0, 1'b1, 5'(16 + i), 1'b1);
      tick();
      n_tests++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid %0d: got %b want 1", i, bus.r_valid); end
      exp_d = sb.pop_front();
      n_tests++; if (bus.r_data !== exp_d) begin n_fail++; $display("FAIL stream_data %0d: got %h want %h", i, bus.r_data, exp_d); end
    end
    idle();
    tick();
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b want 0", bus.r_valid); end
    n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_dropped();
    test_mid_reset();
    test_streaming();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
